// File: rtl/light_display_driver_if.sv
// Bus between the traffic-light sequencer side and the lamp/7-segment driver.
interface light_display_driver_if;
  logic [1:0]  phase;
  logic [31:0] count;
  logic [3:0]  lamp;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [7:0]  bcd;
  logic        busy;

  modport master (output phase, count, input lamp, seg, an, bcd, busy);
  modport slave  (input phase, count, output lamp, seg, an, bcd, busy);
endinterface

// File: rtl/light_display_driver.sv
// Lamp + multiplexed 7-segment driver for the traffic-light sequencer.
// Converts the countdown to BCD with an iterative shift-add-3 engine.
module light_display_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000,
  parameter int WARN_T    = 3,
  parameter int MAX_SHOW  = 99
) (
  input  logic clk,
  input  logic reset,
  light_display_driver_if.slave bus
);
  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SC_MAX = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BL_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t      state, nxt;
  logic [1:0]  phase_q;
  logic [31:0] count_q, last_cnt;
  logic [6:0]  v, clamp;
  logic [7:0]  scr, adj, scr_sh, bcd_q;
  logic [2:0]  sh_cnt;
  logic        busy_q, mismatch;
  logic [SW-1:0] sc_cnt;
  logic [1:0]  idx;
  logic [3:0]  an_q;
  logic [7:0]  seg_q, seg_d;
  logic [BW-1:0] bl_cnt;
  logic        blink_q, warn;
  logic [3:0]  lamp_q;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'hC0;  4'd1: seg7 = 8'hF9;
      4'd2: seg7 = 8'hA4;  4'd3: seg7 = 8'hB0;
      4'd4: seg7 = 8'h99;  4'd5: seg7 = 8'h92;
      4'd6: seg7 = 8'h82;  4'd7: seg7 = 8'hF8;
      4'd8: seg7 = 8'h80;  4'd9: seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign mismatch = (count_q != last_cnt);
  assign clamp    = (count_q > 32'(MAX_SHOW)) ? 7'(MAX_SHOW) : count_q[6:0];
  assign warn     = (count_q >= 32'd1) && (count_q <= 32'(WARN_T));

  // Register the sequencer inputs once before any use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      count_q <= '0;
    end else begin
      phase_q <= bus.phase;
      count_q <= bus.count;
    end
  end

  // Converter next state, plus one adjust-then-shift step of the scratch BCD.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (mismatch) nxt = LOAD;
      LOAD:    nxt = SHIFT;
      SHIFT:   if (sh_cnt == 3'd7) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    adj = scr;
    if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
    if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
    scr_sh = {adj[6:0], v[6]};
  end

  // Converter state and datapath; work is keyed on the state being entered,
  // so the load lands on the detect edge and bcd lands on the DONE edge.
  // busy stays up across DONE/IDLE when a newer count is already waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      bcd_q    <= '0;
      last_cnt <= '0;
      v        <= '0;
      scr      <= '0;
      sh_cnt   <= '0;
    end else begin
      state  <= nxt;
      busy_q <= (nxt == LOAD) || (nxt == SHIFT) || mismatch;
      case (nxt)
        LOAD: begin
          v        <= clamp;
          last_cnt <= count_q;
          scr      <= '0;
          sh_cnt   <= '0;
        end
        SHIFT: begin
          scr    <= scr_sh;
          v      <= {v[5:0], 1'b0};
          sh_cnt <= sh_cnt + 3'd1;
        end
        DONE:    bcd_q <= scr;
        default: ;
      endcase
    end
  end

  // Pattern for the digit currently selected by the scan index.
  always_comb begin
    seg_d = 8'hFF;
    case (idx)
      2'd0: seg_d = seg7(bcd_q[3:0]);
      2'd1: seg_d = (bcd_q[7:4] == 4'd0) ? 8'hFF : seg7(bcd_q[7:4]);
      2'd2: case (phase_q)
              2'd0: seg_d = 8'hBF;
              2'd1: seg_d = 8'hC7;
              2'd2: seg_d = 8'h8E;
              default: seg_d = 8'hAF;
            endcase
      default: seg_d = 8'hFF;
    endcase
  end

  // Scan prescaler and digit index; an and seg are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc_cnt <= '0;
      idx    <= '0;
      an_q   <= 4'hF;
      seg_q  <= 8'hFF;
    end else begin
      if (sc_cnt == SC_MAX) begin
        sc_cnt <= '0;
        idx    <= idx + 2'd1;
      end else begin
        sc_cnt <= sc_cnt + 1'b1;
      end
      an_q  <= ~(4'b0001 << idx);
      seg_q <= seg_d;
    end
  end

  // Free-running blink half-period divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bl_cnt  <= '0;
      blink_q <= 1'b0;
    end else if (bl_cnt == BL_MAX) begin
      bl_cnt  <= '0;
      blink_q <= ~blink_q;
    end else begin
      bl_cnt <= bl_cnt + 1'b1;
    end
  end

  // One-hot lamp on the phase code, blinking in the final WARN_T seconds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lamp_q <= '0;
    else       lamp_q <= (4'b0001 << phase_q) & (warn ? {4{blink_q}} : 4'hF);
  end

  assign bus.lamp = lamp_q;
  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.bcd  = bcd_q;
  assign bus.busy = busy_q;
endmodule

// File: doc/light_display_driver.md
Name: light_display_driver

Overview:
- Downstream consumer of the traffic-light sequence generator. Takes its 2-bit phase code and 32-bit countdown value.
- Drives four direction/stop lamps, with a warning blink in the final seconds of each phase.
- Drives a 4-digit multiplexed, active-low 7-segment display: phase letter plus a two-digit countdown.
- Binary-to-BCD conversion is an iterative shift-add-3 engine with a start/busy handshake.

Parameters:
- SCAN_DIV, 50000: clk cycles each display digit stays enabled (minimum 2).
- BLINK_DIV, 25000000: clk cycles per blink half-period (minimum 2).
- WARN_T, 3: count values 1..WARN_T make the active lamp blink.
- MAX_SHOW, 99: count values above this are shown as 99.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- phase, input, 2: phase code. 00 OFF/stop, 01 LEFT, 10 FORWARD, 11 RIGHT.
- count, input, 32: remaining seconds of the current phase.
- lamp, output, 4: one lamp per phase code. [0] stop, [1] left, [2] forward, [3] right. Active high.
- seg, output, 8: segments, active low. [7] dp, [6:0] g..a. dp is always 1.
- an, output, 4: digit enables, active low, one-hot-zero.
- bcd, output, 8: last converted value. [7:4] tens, [3:0] ones.
- busy, output, 1: high while a conversion is in progress.

Behaviour:
- Reset (asynchronous, any time, including mid-conversion) sets:
  - lamp=0, seg=8'hFF, an=4'hF, bcd=0, busy=0.
  - All dividers and the scan index to 0.
  - Converter to IDLE; last_cnt register to 0.
- phase and count are registered once (1 cycle) before any use.
- Converter FSM, states IDLE -> LOAD -> SHIFT -> DONE -> IDLE:
  - IDLE: if the registered count differs from last_cnt, go to LOAD and set busy=1.
  - LOAD: latch v = min(count, MAX_SHOW) as 7 bits; last_cnt <= registered count; clear scratch BCD.
  - SHIFT: 7 cycles. Each cycle, add 3 to any BCD nibble >= 5, then shift left one bit, taking in the MSB of v.
  - DONE: bcd <= scratch; busy <= 0; return to IDLE.
  - Latency: bcd updates 10 cycles after count changes at the input pins (1 register + LOAD + 7 SHIFT + DONE).
- Count changing while busy: the current conversion completes with no abort. IDLE then sees the mismatch and restarts next cycle, so the final bcd always matches the final count.
- Scan:
  - A prescaler counts 0..SCAN_DIV-1. On wrap, the scan index advances 0 -> 1 -> 2 -> 3 -> 0.
  - an = ~(4'b0001 << idx); an and seg are registered together.
- Digit content:
  - idx 0: ones digit.
  - idx 1: tens digit, blanked (8'hFF) when tens==0.
  - idx 2: phase letter. OFF '-' 8'hBF, LEFT 'L' 8'hC7, FORWARD 'F' 8'h8E, RIGHT 'r' 8'hAF.
  - idx 3: blank, 8'hFF.
- Decimal digit codes: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90.
- Blink toggle: free-running divider counting 0..BLINK_DIV-1; blink_q toggles on wrap.
- lamp is registered and one-hot on the registered phase code:
  - The active lamp bit is ANDed with blink_q when 1 <= count <= WARN_T.
  - Otherwise it is steady on.
  - count=0 gives a steady lamp.
- Width rules:
  - The clamp compares all 32 bits, so count=32'hFFFFFFFF shows 99.
  - All counters wrap exactly at their parameter value; there is no overflow.

Test Plan (SCAN_DIV=4, BLINK_DIV=8):
- Reset, then hold phase=00, count=0 -> lamp=0001 steady, bcd=00, busy never rises. Digits across a full scan: idx0 C0, idx1 FF, idx2 BF, idx3 FF.
- At t0 set phase=10, count=15 -> busy high t0+2..t0+9, bcd=8'h15 at t0+10, lamp=0100 steady. Scan shows an=1110/seg=92, an=1101/seg=F9, an=1011/seg=8E.
- Set count=150, then count=32'hFFFFFFFF -> bcd=8'h99 both times. Digits idx0 90, idx1 90.
- Set phase=01, count=3 -> lamp[1] toggles every 8 cycles, other lamp bits 0. Then count=0 -> lamp=0010 steady.
- Set count=12, then count=7 three cycles later (mid-SHIFT) -> bcd passes 8'h12, then settles at 8'h07. busy drops only after the second conversion; tens digit blanked (seg FF on an=1101).
- Assert reset during SHIFT -> all outputs at reset values on the same cycle. After release with count=9, bcd=8'h09 within 10 cycles.
